mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single `memory` instance between two requesters: the fetch stage (port I, instruction reads) and `memory_stage` (port D, data reads/writes).
- Sits between those stages and the memory's valid/ready request channel and response channel.
- One transaction is outstanding at a time. Each response is routed back to the requester that issued it.

Parameters:
- ADDRESS_WIDTH, `ADDRESS_WIDTH, address bus width.
- DATA_WIDTH, `DATA_WIDTH, data bus width.
- CMD_WIDTH, `MEM_CMD_WIDTH, width of the command field. Encodings are `MEM_CMD_READ and `MEM_CMD_WRITE.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock; all state changes on the rising edge.
  - reset  in  1  synchronous, active-high reset.
- Port I (fetch):
  - i_i_valid  in  1  fetch request valid.
  - i_i_addr  in  ADDRESS_WIDTH  fetch address.
  - o_i_ready  out  1  fetch request accepted this cycle.
  - o_i_res_valid  out  1  one-cycle pulse: fetch response.
  - o_i_data  out  DATA_WIDTH  fetch read data.
- Port D (memory_stage):
  - i_d_valid  in  1  data request valid.
  - i_d_addr  in  ADDRESS_WIDTH  data address.
  - i_d_cmd  in  CMD_WIDTH  read or write.
  - i_d_data  in  DATA_WIDTH  write data.
  - o_d_ready  out  1  data request accepted this cycle.
  - o_d_res_valid  out  1  one-cycle pulse: data response.
  - o_d_data  out  DATA_WIDTH  read data.
- Memory side:
  - o_mem_valid  out  1  request to memory (drives memory i_valid).
  - o_mem_addr  out  ADDRESS_WIDTH  memory address.
  - o_mem_cmd  out  CMD_WIDTH  memory command.
  - o_mem_data  out  DATA_WIDTH  memory write data.
  - i_mem_ready  in  1  memory o_ready.
  - o_mem_res_ready  out  1  drives memory i_res_ready.
  - i_mem_res_valid  in  1  memory o_res_valid.
  - i_mem_data  in  DATA_WIDTH  memory o_data.
- Status:
  - o_busy  out  1  a transaction is in flight (state != IDLE).
  - o_owner  out  1  owner of current transaction: 0 = I, 1 = D.

Behaviour:
- Reset values:
  - state = IDLE.
  - All valid, ready and res_valid outputs = 0.
  - o_busy = 0, o_owner = 0.
  - Data, address and command registers = 0.
  - last_grant = 1 (D).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - o_i_ready and o_d_ready are combinational grant signals. At most one is high.
  - If any request valid: the winner gets ready = 1 this cycle.
  - The winner's addr, cmd and data are latched, plus owner.
  - Port I cmd is forced to `MEM_CMD_READ.
  - Next state is ISSUE.
  - Without a valid request, stay in IDLE.
- ISSUE:
  - o_mem_valid = 1 with the latched fields held stable.
  - On i_mem_ready = 1, go to WAIT.
  - Otherwise hold; the request is never dropped or changed.
- WAIT:
  - o_mem_res_ready = 1.
  - On i_mem_res_valid, register i_mem_data into the owner's o_*_data and pulse the owner's o_*_res_valid on the next cycle, for exactly one cycle.
  - Go to IDLE on that same edge.
- Every command, read or write, completes with exactly one memory response. For writes, o_d_data is don't-care.
- Latency:
  - Request accepted at cycle T; o_mem_valid at T+1.
  - If memory is ready at T+1 and responds at Tr, then o_*_res_valid occurs at Tr+1.
  - A new grant is possible at Tr+1, with o_mem_valid again at Tr+2.
- Arbitration: when both ports are valid in IDLE, D wins (fixed priority).
- Requests arriving in ISSUE or WAIT see ready = 0. Requesters hold valid and fields until ready.
- i_mem_res_valid outside WAIT is ignored; o_mem_res_ready = 0 there.
- Non-owner o_*_data holds its previous value.
- Reset mid-operation: returns to IDLE and clears all pulses. Memory shares the same reset, so no stale response can follow.
- Register o_mem_* outputs; no combinational path from i_mem_* to the memory-side outputs.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - On a tie in IDLE, grant the port that did not win last (last_grant).
  - last_grant updates on every grant.
  - The first tie after reset goes to I.
- Not defined: fixed priority, D over I. last_grant is not implemented.

Decomposition:
- header.v holds `MEM_CMD_WIDTH, `MEM_CMD_READ/`MEM_CMD_WRITE, the port IDs `ARB_PORT_I = 0 and `ARB_PORT_D = 1, and the FSM state encodings.
- One combinational sub-module, arb_grant_sel:
  - Inputs: i_i_valid, i_d_valid, last_grant.
  - Outputs: one-hot grant.
  - Holds the ROUND_ROBIN_EN ifdef.

Test Plan:
- I-only read 0x10, memory ready immediately, response 0xDEADBEEF two cycles later -> o_i_ready at T; o_mem_valid at T+1 with addr 0x10 and cmd READ; o_i_res_valid exactly one cycle with 0xDEADBEEF; o_d_res_valid stays 0.
- I and D both valid at the same cycle, D a write of 0x55 to 0x20 -> D granted first; I held (ready = 0) until D's ack; I is granted at the cycle after the ack.
- With MEM_ARB_ROUND_ROBIN_EN: both valid continuously -> grants alternate I, D, I, D.
- i_mem_ready held low 5 cycles in ISSUE -> o_mem_valid, addr, cmd and data stable all 5 cycles; exactly one transfer.
- Spurious i_mem_res_valid in IDLE -> no res_valid pulse on either port.
- reset asserted in WAIT -> next cycle IDLE; all outputs 0; the subsequent request is handled normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and types for the two-port memory arbiter.
//   - Default bus widths, memory command encodings, port identifiers.
//   - FSM state encoding shared by the arbiter top.
//   - grant_owner(): maps a one-hot grant vector onto a port identifier.
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

  localparam int MEM_ADDRESS_WIDTH = 32;
  localparam int MEM_DATA_WIDTH    = 32;
  localparam int MEM_CMD_WIDTH     = 2;

  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_READ  = 2'd0;
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_WRITE = 2'd1;

  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Grant vector layout: bit 0 = port I, bit 1 = port D.
  function automatic logic grant_owner(input logic [1:0] grant);
    return grant[1] ? ARB_PORT_D : ARB_PORT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port (I), data port (D), memory request /
// response channels and status outputs of mem_arbiter.
//   modport slave  : the arbiter's view (drives all o_* signals).
//   modport master : the environment's view (drives all i_* signals).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
  parameter int CMD_WIDTH     = MEM_CMD_WIDTH
) ();

  // Port I (fetch)
  logic                     i_i_valid;
  logic [ADDRESS_WIDTH-1:0] i_i_addr;
  logic                     o_i_ready;
  logic                     o_i_res_valid;
  logic [DATA_WIDTH-1:0]    o_i_data;
  // Port D (memory_stage)
  logic                     i_d_valid;
  logic [ADDRESS_WIDTH-1:0] i_d_addr;
  logic [CMD_WIDTH-1:0]     i_d_cmd;
  logic [DATA_WIDTH-1:0]    i_d_data;
  logic                     o_d_ready;
  logic                     o_d_res_valid;
  logic [DATA_WIDTH-1:0]    o_d_data;
  // Memory side
  logic                     o_mem_valid;
  logic [ADDRESS_WIDTH-1:0] o_mem_addr;
  logic [CMD_WIDTH-1:0]     o_mem_cmd;
  logic [DATA_WIDTH-1:0]    o_mem_data;
  logic                     i_mem_ready;
  logic                     o_mem_res_ready;
  logic                     i_mem_res_valid;
  logic [DATA_WIDTH-1:0]    i_mem_data;
  // Status
  logic                     o_busy;
  logic                     o_owner;

  modport slave (
    input  i_i_valid, i_i_addr,
    output o_i_ready, o_i_res_valid, o_i_data,
    input  i_d_valid, i_d_addr, i_d_cmd, i_d_data,
    output o_d_ready, o_d_res_valid, o_d_data,
    output o_mem_valid, o_mem_addr, o_mem_cmd, o_mem_data,
    input  i_mem_ready,
    output o_mem_res_ready,
    input  i_mem_res_valid, i_mem_data,
    output o_busy, o_owner
  );

  modport master (
    output i_i_valid, i_i_addr,
    input  o_i_ready, o_i_res_valid, o_i_data,
    output i_d_valid, i_d_addr, i_d_cmd, i_d_data,
    input  o_d_ready, o_d_res_valid, o_d_data,
    input  o_mem_valid, o_mem_addr, o_mem_cmd, o_mem_data,
    output i_mem_ready,
    input  o_mem_res_ready,
    output i_mem_res_valid, i_mem_data,
    input  o_busy, o_owner
  );

endinterface

// File: rtl/mem_arbiter_arb_grant_sel.sv
// arb_grant_sel: combinational grant selection between port I and port D.
//   i_i_valid    : fetch request valid
//   i_d_valid    : data request valid
//   i_last_grant : port that won the previous grant (only with
//                  MEM_ARB_ROUND_ROBIN_EN defined)
//   o_grant      : one-hot grant, bit 0 = I, bit 1 = D, zero when idle
// Macro MEM_ARB_ROUND_ROBIN_EN: ties go to the port that did not win last;
// without it D always wins a tie.
module arb_grant_sel
  import mem_arbiter_pkg::*;
(
  input  logic       i_i_valid,
  input  logic       i_d_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       i_last_grant,
`endif
  output logic [1:0] o_grant
);

  // Pick at most one requester; only the tie case depends on configuration.
  always_comb begin
    o_grant = 2'b00;
    if (i_i_valid && i_d_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (i_last_grant == ARB_PORT_D) begin
        o_grant = 2'b01;
      end else begin
        o_grant = 2'b10;
      end
`else
      o_grant = 2'b10;
`endif
    end else if (i_d_valid) begin
      o_grant = 2'b10;
    end else if (i_i_valid) begin
      o_grant = 2'b01;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between the fetch stage (port I, reads only)
// and memory_stage (port D, reads/writes). One transaction in flight at a time;
// the response is steered back to the port that issued it.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_arbiter_if.slave carrying port I, port D, the memory
//                request/response channels and o_busy / o_owner status
// FSM: IDLE (grant) -> ISSUE (present request) -> WAIT (await response).
// Macro MEM_ARB_ROUND_ROBIN_EN: enables last_grant tracking for tie-breaking.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
  parameter int CMD_WIDTH     = MEM_CMD_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e               r_state;
  arb_state_e               w_next_state;
  logic                     r_owner;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [CMD_WIDTH-1:0]     r_cmd;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_i_data;
  logic [DATA_WIDTH-1:0]    r_d_data;
  logic                     r_i_res_valid;
  logic                     r_d_res_valid;
  logic [1:0]               w_grant;
  logic                     w_accept;
  logic                     w_resp;
  logic                     w_i_ready;
  logic                     w_d_ready;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                     r_last_grant;
`endif

  arb_grant_sel u_grant_sel (
    .i_i_valid    (bus.i_i_valid),
    .i_d_valid    (bus.i_d_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last_grant),
`endif
    .o_grant      (w_grant)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state plus the grant strobes; ready is only offered in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    w_i_ready    = 1'b0;
    w_d_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_accept     = 1'b1;
          w_i_ready    = w_grant[0];
          w_d_ready    = w_grant[1];
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_mem_ready) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_res_valid) begin
          w_resp       = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Request latch on grant and response capture/steering on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner       <= ARB_PORT_I;
      r_addr        <= '0;
      r_cmd         <= '0;
      r_wdata       <= '0;
      r_i_data      <= '0;
      r_d_data      <= '0;
      r_i_res_valid <= 1'b0;
      r_d_res_valid <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant  <= ARB_PORT_D;
`endif
    end else begin
      // Response pulses last exactly one cycle.
      r_i_res_valid <= 1'b0;
      r_d_res_valid <= 1'b0;
      if (w_accept) begin
        r_owner <= grant_owner(w_grant);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        r_last_grant <= grant_owner(w_grant);
`endif
        if (w_grant[1]) begin
          r_addr  <= bus.i_d_addr;
          r_cmd   <= bus.i_d_cmd;
          r_wdata <= bus.i_d_data;
        end else begin
          // Fetch has no command or write data of its own.
          r_addr  <= bus.i_i_addr;
          r_cmd   <= CMD_WIDTH'(MEM_CMD_READ);
          r_wdata <= '0;
        end
      end
      if (w_resp) begin
        if (r_owner == ARB_PORT_D) begin
          r_d_data      <= bus.i_mem_data;
          r_d_res_valid <= 1'b1;
        end else begin
          r_i_data      <= bus.i_mem_data;
          r_i_res_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_i_ready       = w_i_ready;
  assign bus.o_d_ready       = w_d_ready;
  assign bus.o_i_res_valid   = r_i_res_valid;
  assign bus.o_d_res_valid   = r_d_res_valid;
  assign bus.o_i_data        = r_i_data;
  assign bus.o_d_data        = r_d_data;
  // Memory-side outputs come only from registers, never from i_mem_*.
  assign bus.o_mem_valid     = (r_state == ST_ISSUE);
  assign bus.o_mem_addr      = r_addr;
  assign bus.o_mem_cmd       = r_cmd;
  assign bus.o_mem_data      = r_wdata;
  assign bus.o_mem_res_ready = (r_state == ST_WAIT);
  assign bus.o_busy          = (r_state != ST_IDLE);
  assign bus.o_owner         = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter plus
// hand-written multi-cycle sequences (priority/hold, continuous contention,
// memory stall, spurious response, reset during WAIT).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   xfer_cnt;
  logic [31:0] model_i_data;

  mem_arbiter_if bus_if ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count memory request handshakes.
  always @(posedge clk) begin
    if (bus_if.o_mem_valid && bus_if.i_mem_ready) xfer_cnt <= xfer_cnt + 1;
  end

  typedef struct {
    logic        i_valid;
    logic [31:0] i_addr;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [1:0]  d_cmd;
    logic [31:0] d_data;
    logic [31:0] rdata;
    logic        exp_owner;
    logic [31:0] exp_addr;
    logic [1:0]  exp_cmd;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.i_i_valid       = 1'b0;
    bus_if.i_i_addr        = 32'h0;
    bus_if.i_d_valid       = 1'b0;
    bus_if.i_d_addr        = 32'h0;
    bus_if.i_d_cmd         = 2'd0;
    bus_if.i_d_data        = 32'h0;
    bus_if.i_mem_ready     = 1'b0;
    bus_if.i_mem_res_valid = 1'b0;
    bus_if.i_mem_data      = 32'h0;
  endtask

  // From ISSUE: memory accepts at once, responds the next cycle with rdata.
  task automatic complete(input string tag, input logic owner, input logic [1:0] cmd,
                          input logic [31:0] rdata);
    bus_if.i_mem_ready = 1'b1;
    tick();
    bus_if.i_mem_ready = 1'b0;
    chk({tag, ".wait_mem_valid"}, 32'(bus_if.o_mem_valid), 32'd0);
    chk({tag, ".res_ready"}, 32'(bus_if.o_mem_res_ready), 32'd1);
    bus_if.i_mem_res_valid = 1'b1;
    bus_if.i_mem_data      = rdata;
    tick();
    bus_if.i_mem_res_valid = 1'b0;
    chk({tag, ".i_res_valid"}, 32'(bus_if.o_i_res_valid), 32'(owner == ARB_PORT_I));
    chk({tag, ".d_res_valid"}, 32'(bus_if.o_d_res_valid), 32'(owner == ARB_PORT_D));
    chk({tag, ".busy_after"}, 32'(bus_if.o_busy), 32'd0);
    if (owner == ARB_PORT_I) begin
      chk({tag, ".i_data"}, bus_if.o_i_data, rdata);
      model_i_data = rdata;
    end else begin
      if (cmd == MEM_CMD_READ) chk({tag, ".d_data"}, bus_if.o_d_data, rdata);
      chk({tag, ".i_data_hold"}, bus_if.o_i_data, model_i_data);
    end
  endtask

  // One full transaction from a table record, starting in IDLE at a negedge.
  task automatic run_vec(input string tag, input vec_t v);
    bus_if.i_i_valid = v.i_valid;
    bus_if.i_i_addr  = v.i_addr;
    bus_if.i_d_valid = v.d_valid;
    bus_if.i_d_addr  = v.d_addr;
    bus_if.i_d_cmd   = v.d_cmd;
    bus_if.i_d_data  = v.d_data;
    #1;
    chk({tag, ".i_ready"}, 32'(bus_if.o_i_ready), 32'(v.exp_owner == ARB_PORT_I));
    chk({tag, ".d_ready"}, 32'(bus_if.o_d_ready), 32'(v.exp_owner == ARB_PORT_D));
    tick();
    bus_if.i_i_valid = 1'b0;
    bus_if.i_d_valid = 1'b0;
    chk({tag, ".mem_valid"}, 32'(bus_if.o_mem_valid), 32'd1);
    chk({tag, ".mem_addr"}, bus_if.o_mem_addr, v.exp_addr);
    chk({tag, ".mem_cmd"}, 32'(bus_if.o_mem_cmd), 32'(v.exp_cmd));
    chk({tag, ".mem_data"}, bus_if.o_mem_data, v.exp_wdata);
    chk({tag, ".busy"}, 32'(bus_if.o_busy), 32'd1);
    chk({tag, ".owner"}, 32'(bus_if.o_owner), 32'(v.exp_owner));
    complete(tag, v.exp_owner, v.exp_cmd, v.rdata);
    tick();
    chk({tag, ".i_pulse_end"}, 32'(bus_if.o_i_res_valid), 32'd0);
    chk({tag, ".d_pulse_end"}, 32'(bus_if.o_d_res_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    model_i_data = 32'h0;
  endtask

  initial begin
    logic first_is_d;
    logic exp_seq[4];
    int   xfer_before;
    total    = 0;
    bad      = 0;
    xfer_cnt = 0;
    reset    = 1'b1;
    idle_inputs();

    //              iv    i_addr        dv    d_addr        cmd            d_data        rdata         own         addr          cmd            wdata
    vecs[0] = '{1'b1, 32'h10,       1'b0, 32'h0,        MEM_CMD_READ,  32'h0,        32'hDEADBEEF, ARB_PORT_I, 32'h10,       MEM_CMD_READ,  32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h40,       MEM_CMD_READ,  32'h0,        32'h12345678, ARB_PORT_D, 32'h40,       MEM_CMD_READ,  32'h0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 32'h20,       MEM_CMD_WRITE, 32'h55,       32'h0,        ARB_PORT_D, 32'h20,       MEM_CMD_WRITE, 32'h55};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    vecs[3] = '{1'b1, 32'h30,       1'b1, 32'h44,       MEM_CMD_READ,  32'h99,       32'h0BADF00D, ARB_PORT_I, 32'h30,       MEM_CMD_READ,  32'h0};
`else
    vecs[3] = '{1'b1, 32'h30,       1'b1, 32'h44,       MEM_CMD_READ,  32'h99,       32'h0BADF00D, ARB_PORT_D, 32'h44,       MEM_CMD_READ,  32'h99};
`endif
    vecs[4] = '{1'b1, 32'h3FC,      1'b0, 32'h0,        MEM_CMD_READ,  32'h0,        32'hA5A5A5A5, ARB_PORT_I, 32'h3FC,      MEM_CMD_READ,  32'h0};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, MEM_CMD_WRITE, 32'hFFFFFFFF, 32'h0,        ARB_PORT_D, 32'hFFFFFFFC, MEM_CMD_WRITE, 32'hFFFFFFFF};

    // Reset state.
    tick();
    tick();
    chk("rst.busy", 32'(bus_if.o_busy), 32'd0);
    chk("rst.owner", 32'(bus_if.o_owner), 32'd0);
    chk("rst.mem_valid", 32'(bus_if.o_mem_valid), 32'd0);
    chk("rst.res_ready", 32'(bus_if.o_mem_res_ready), 32'd0);
    chk("rst.i_res_valid", 32'(bus_if.o_i_res_valid), 32'd0);
    chk("rst.d_res_valid", 32'(bus_if.o_d_res_valid), 32'd0);
    chk("rst.mem_addr", bus_if.o_mem_addr, 32'h0);
    chk("rst.i_data", bus_if.o_i_data, 32'h0);
    reset = 1'b0;
    model_i_data = 32'h0;
    tick();

    for (int k = 0; k < 6; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Both requesters at once; loser holds valid and wins right after the ack.
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_is_d = 1'b0;
`else
    first_is_d = 1'b1;
`endif
    bus_if.i_i_valid = 1'b1;
    bus_if.i_i_addr  = 32'h100;
    bus_if.i_d_valid = 1'b1;
    bus_if.i_d_addr  = 32'h20;
    bus_if.i_d_cmd   = MEM_CMD_WRITE;
    bus_if.i_d_data  = 32'h55;
    #1;
    chk("tie.d_ready", 32'(bus_if.o_d_ready), 32'(first_is_d));
    chk("tie.i_ready", 32'(bus_if.o_i_ready), 32'(!first_is_d));
    tick();
    if (first_is_d) bus_if.i_d_valid = 1'b0;
    else bus_if.i_i_valid = 1'b0;
    chk("tie.issue_i_ready", 32'(bus_if.o_i_ready), 32'd0);
    chk("tie.issue_d_ready", 32'(bus_if.o_d_ready), 32'd0);
    chk("tie.first_addr", bus_if.o_mem_addr, first_is_d ? 32'h20 : 32'h100);
    complete("tie.first", first_is_d, first_is_d ? MEM_CMD_WRITE : MEM_CMD_READ, 32'h77);
    #1;
    chk("tie.second_i_ready", 32'(bus_if.o_i_ready), 32'(first_is_d));
    chk("tie.second_d_ready", 32'(bus_if.o_d_ready), 32'(!first_is_d));
    tick();
    bus_if.i_i_valid = 1'b0;
    bus_if.i_d_valid = 1'b0;
    chk("tie.second_addr", bus_if.o_mem_addr, first_is_d ? 32'h100 : 32'h20);
    chk("tie.second_owner", 32'(bus_if.o_owner), 32'(!first_is_d));
    complete("tie.second", !first_is_d, first_is_d ? MEM_CMD_READ : MEM_CMD_WRITE, 32'h88);
    tick();

    // Continuous contention over four transactions.
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{ARB_PORT_I, ARB_PORT_D, ARB_PORT_I, ARB_PORT_D};
`else
    exp_seq = '{ARB_PORT_D, ARB_PORT_D, ARB_PORT_D, ARB_PORT_D};
`endif
    bus_if.i_i_valid = 1'b1;
    bus_if.i_i_addr  = 32'h200;
    bus_if.i_d_valid = 1'b1;
    bus_if.i_d_addr  = 32'h300;
    bus_if.i_d_cmd   = MEM_CMD_READ;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont%0d.i_ready", k), 32'(bus_if.o_i_ready), 32'(exp_seq[k] == ARB_PORT_I));
      chk($sformatf("cont%0d.d_ready", k), 32'(bus_if.o_d_ready), 32'(exp_seq[k] == ARB_PORT_D));
      tick();
      bus_if.i_mem_ready = 1'b1;
      tick();
      bus_if.i_mem_ready     = 1'b0;
      bus_if.i_mem_res_valid = 1'b1;
      bus_if.i_mem_data      = 32'h1000 + 32'(k);
      tick();
      bus_if.i_mem_res_valid = 1'b0;
      chk($sformatf("cont%0d.res", k),
          {30'd0, bus_if.o_d_res_valid, bus_if.o_i_res_valid},
          (exp_seq[k] == ARB_PORT_D) ? 32'd2 : 32'd1);
    end
    bus_if.i_i_valid = 1'b0;
    bus_if.i_d_valid = 1'b0;
    tick();

    // Memory stalls five cycles in ISSUE; request must stay put.
    do_reset();
    bus_if.i_d_valid = 1'b1;
    bus_if.i_d_addr  = 32'h88;
    bus_if.i_d_cmd   = MEM_CMD_WRITE;
    bus_if.i_d_data  = 32'hCAFE;
    tick();
    bus_if.i_d_valid = 1'b0;
    xfer_before = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d.valid", k), 32'(bus_if.o_mem_valid), 32'd1);
      chk($sformatf("stall%0d.addr", k), bus_if.o_mem_addr, 32'h88);
      chk($sformatf("stall%0d.cmd", k), 32'(bus_if.o_mem_cmd), 32'(MEM_CMD_WRITE));
      chk($sformatf("stall%0d.data", k), bus_if.o_mem_data, 32'hCAFE);
      tick();
    end
    complete("stall.done", ARB_PORT_D, MEM_CMD_WRITE, 32'h0);
    chk("stall.xfers", 32'(xfer_cnt - xfer_before), 32'd1);
    tick();

    // Spurious memory response while idle.
    bus_if.i_mem_res_valid = 1'b1;
    bus_if.i_mem_data      = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("spur%0d.res", k), {30'd0, bus_if.o_d_res_valid, bus_if.o_i_res_valid}, 32'd0);
      chk($sformatf("spur%0d.busy", k), 32'(bus_if.o_busy), 32'd0);
      chk($sformatf("spur%0d.i_data", k), bus_if.o_i_data, model_i_data);
    end
    bus_if.i_mem_res_valid = 1'b0;
    tick();

    // Reset while waiting for a response.
    bus_if.i_i_valid = 1'b1;
    bus_if.i_i_addr  = 32'h500;
    tick();
    bus_if.i_i_valid   = 1'b0;
    bus_if.i_mem_ready = 1'b1;
    tick();
    bus_if.i_mem_ready = 1'b0;
    chk("rwait.in_wait", 32'(bus_if.o_mem_res_ready), 32'd1);
    reset                  = 1'b1;
    bus_if.i_mem_res_valid = 1'b1;
    bus_if.i_mem_data      = 32'hEEEE;
    tick();
    reset                  = 1'b0;
    bus_if.i_mem_res_valid = 1'b0;
    model_i_data           = 32'h0;
    chk("rwait.busy", 32'(bus_if.o_busy), 32'd0);
    chk("rwait.owner", 32'(bus_if.o_owner), 32'd0);
    chk("rwait.mem_valid", 32'(bus_if.o_mem_valid), 32'd0);
    chk("rwait.res_ready", 32'(bus_if.o_mem_res_ready), 32'd0);
    chk("rwait.res", {30'd0, bus_if.o_d_res_valid, bus_if.o_i_res_valid}, 32'd0);
    chk("rwait.i_data", bus_if.o_i_data, 32'h0);
    chk("rwait.mem_addr", bus_if.o_mem_addr, 32'h0);
    run_vec("post_rst_i", vecs[0]);
    run_vec("post_rst_d", vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
